ntt_result_unloader: RTL and testbench

//  Drains the N completed NTT coefficients from the coefficient RAM after the last butterfly stage
//  and streams them to the downstream consumer over a valid/ready interface.

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/ntt_result_unloader_if.sv | 14 +
 rtl/ntt_skid_fifo.sv | 42 ++++
 rtl/ntt_result_unloader.sv | 102 ++++++++++
 tb/tb_ntt_result_unloader.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: coefficient/ring constants, unload FSM states and the
// bit-reversal helper also used by the bit_reverse loader.
package ntt_pkg;

  localparam int DATA_W    = 13;
  localparam int RING_SIZE = 256;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } unload_state_e;

  // Reverses the low addr_w bits of idx; bits above addr_w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int addr_w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < addr_w) r[i] = idx[addr_w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_result_unloader_if.sv
// Valid/ready coefficient stream from the unloader to the downstream consumer.
interface ntt_result_unloader_if #(
  parameter int DATA_W = ntt_pkg::DATA_W
);

  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (output dout, dout_valid, dout_last, input dout_ready);
  modport slave  (input dout, dout_valid, dout_last, output dout_ready);

endinterface

// File: rtl/ntt_skid_fifo.sv
// 2-entry fall-through FIFO: when empty, the pushed word is presented on pop_data
// in the same cycle, so a push and pop together pass straight through.
module ntt_skid_fifo #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

  // NOTE: storage is deliberately not reset; count and the pointers decide
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = (count == 2'd0) ? push_data : mem[rd_ptr];

endmodule

// File: rtl/ntt_result_unloader.sv
// Streams RING_SIZE coefficients out of the coefficient RAM after the last NTT stage.
// Define NTT_UNLOAD_BITREV_EN to read the RAM in bit-reversed address order.
module ntt_result_unloader
  import ntt_pkg::*;
#(
  parameter int DATA_W    = ntt_pkg::DATA_W,
  parameter int RING_SIZE = ntt_pkg::RING_SIZE,
  parameter int ADDR_W    = $clog2(RING_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ram_re,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_W-1:0]     ram_rdata,
  ntt_result_unloader_if.master dout_if,
  output logic                  busy,
  output logic                  done
);

  unload_state_e     state_q, state_d;
  logic [ADDR_W-1:0] rd_idx;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        fifo_count;
  logic [1:0]        credit_used;
  logic              credit_ok;
  logic              last_rd;
  logic              out_valid;
  logic              pop;
  logic [DATA_W:0]   head;

  assign last_rd     = (rd_idx == ADDR_W'(RING_SIZE - 1));
  // Reads in flight count against FIFO space so a stalled consumer never loses data.
  assign credit_used = fifo_count + {1'b0, inflight};
  assign credit_ok   = (credit_used < 2'd2);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ram_re  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = READ;
      READ: begin
        busy   = 1'b1;
        ram_re = credit_ok;
        if (credit_ok && last_rd) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && dout_if.dout_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight      <= ram_re;
      inflight_last <= ram_re && last_rd;
      if (state_q == IDLE) rd_idx <= '0;
      else if (ram_re)     rd_idx <= rd_idx + 1'b1;
    end
  end

`ifdef NTT_UNLOAD_BITREV_EN
  assign ram_addr = ADDR_W'(bitrev(32'(rd_idx), ADDR_W));
`else
  assign ram_addr = rd_idx;
`endif

  ntt_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data ({inflight_last, ram_rdata}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count)
  );

  // Output is gated so that nothing but zeros leaves the block when idle or in reset.
  assign out_valid          = inflight || (fifo_count != 2'd0);
  assign pop                = out_valid && dout_if.dout_ready;
  assign dout_if.dout_valid = out_valid;
  assign dout_if.dout       = out_valid ? head[DATA_W-1:0] : '0;
  assign dout_if.dout_last  = out_valid && head[DATA_W];

endmodule

// File: tb/tb_ntt_result_unloader.sv
// Scoreboard bench for ntt_result_unloader with RING_SIZE=8 and mem[i]=i+100.
module tb_ntt_result_unloader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ram_re;
  logic [2:0]  ram_addr;
  logic [12:0] ram_rdata = '0;
  logic        busy;
  logic        done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] sb [$];
  int          outst = 0;
  int          rd_cnt = 0;
  int          rd_job = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  bit          stalled_prev = 1'b0;
  logic [13:0] prev_out = '0;

  ntt_result_unloader_if #(.DATA_W(13)) sif ();

  ntt_result_unloader #(.DATA_W(13), .RING_SIZE(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .dout_if   (sif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Coefficient RAM: one-cycle read latency, mem[i] = i + 100.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= 13'(100 + int'(ram_addr));
  end

  function automatic logic [2:0] exp_addr(input int i);
    logic [2:0] v;
    v = 3'(i);
`ifdef NTT_UNLOAD_BITREV_EN
    return {v[0], v[1], v[2]};
`else
    return v;
`endif
  endfunction

  task automatic push_job();
    for (int i = 0; i < 8; i++) sb.push_back({(i == 7), 13'(100 + int'(exp_addr(i)))});
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [13:0] got;
    logic [13:0] exp;
    bit          hs;
    @(negedge clk);
    got = {sif.dout_last, sif.dout};
    hs  = sif.dout_valid && sif.dout_ready;
    if (reset) begin
      if (ram_re) begin
        vectors++;
        if (outst >= 2) begin
          miscompares++;
          $display("FAIL credit: ram_re=1 with %0d outstanding, required < 2", outst);
        end
        vectors++;
        if (ram_addr !== exp_addr(rd_job)) begin
          miscompares++;
          $display("FAIL ram_addr: got %0d, required %0d", ram_addr, exp_addr(rd_job));
        end
        rd_cnt++;
        rd_job = (rd_job + 1) % 8;
      end
      if (stalled_prev) begin
        vectors++;
        if (!sif.dout_valid || got !== prev_out) begin
          miscompares++;
          $display("FAIL stall_stable: got valid=%0b last/data=%h, required valid=1 %h",
                   sif.dout_valid, got, prev_out);
        end
      end
      if (hs) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL extra_output: got last/data=%h, required no transfer", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("FAIL stream: got last/data=%h, required %h", got, exp);
          end
        end
        hs_cnt++;
      end
      vectors++;
      if (sif.dout_last && !sif.dout_valid) begin
        miscompares++;
        $display("FAIL last_qual: got dout_last=1 with dout_valid=0, required 0");
      end
      if (done) done_cnt++;
      outst        = outst + int'(ram_re) - int'(hs);
      stalled_prev = sif.dout_valid && !sif.dout_ready;
      prev_out     = got;
    end else begin
      outst        = 0;
      rd_job       = 0;
      stalled_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int base;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != base) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    start          = 1'b0;
    sif.dout_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ram_re, ram_addr, sif.dout, sif.dout_valid, sif.dout_last, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got re=%0b addr=%0d dout=%0d v=%0b l=%0b busy=%0b done=%0b, required all 0",
               ram_re, ram_addr, sif.dout, sif.dout_valid, sif.dout_last, busy, done);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int base_done;
    base_done      = done_cnt;
    sif.dout_ready = 1'b1;
    push_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (sif.dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: got dout_valid=%0b one cycle after start, required 0", sif.dout_valid);
    end
    tick();
    for (int c = 2; c <= 9; c++) begin
      vectors++;
      if (sif.dout_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL throughput: got dout_valid=%0b at cycle %0d, required 1", sif.dout_valid, c);
      end
      tick();
    end
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%0b busy=%0b, required done=1 busy=0", done, busy);
    end
    tick();
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL done_width: got done=%0b busy=%0b, required 0 0", done, busy);
    end
    vectors++;
    if (sb.size() != 0 || done_cnt - base_done != 1) begin
      miscompares++;
      $display("FAIL stream_end: got %0d left, %0d done pulses, required 0 and 1",
               sb.size(), done_cnt - base_done);
    end
  endtask

  task automatic test_toggle_ready();
    int base_done;
    bit seen;
    base_done      = done_cnt;
    seen           = 1'b0;
    sif.dout_ready = 1'b1;
    push_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      sif.dout_ready = ~sif.dout_ready;
      tick();
      if (done_cnt != base_done) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen || sb.size() != 0) begin
      miscompares++;
      $display("FAIL toggle: got done=%0b with %0d left, required done=1 and 0 left", seen, sb.size());
    end
  endtask

  task automatic test_stall();
    int base_rd;
    int gaps;
    bit seen;
    base_rd        = rd_cnt;
    gaps           = 0;
    sif.dout_ready = 1'b0;
    push_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (rd_cnt - base_rd != 2 || ram_re !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_reads: got %0d reads re=%0b busy=%0b, required 2 reads re=0 busy=1",
               rd_cnt - base_rd, ram_re, busy);
    end
    sif.dout_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!sif.dout_valid) gaps++;
      if (sif.dout_valid && sif.dout_last) break;
      tick();
    end
    wait_done(10, seen);
    vectors++;
    if (gaps != 0 || !seen || sb.size() != 0) begin
      miscompares++;
      $display("FAIL stall_release: got %0d gaps done=%0b %0d left, required 0 gaps done=1 0 left",
               gaps, seen, sb.size());
    end
  endtask

  task automatic test_double_start();
    int base_done;
    int base_rd;
    bit seen;
    base_done      = done_cnt;
    base_rd        = rd_cnt;
    sif.dout_ready = 1'b1;
    push_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, seen);
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if (!seen || done_cnt - base_done != 1 || rd_cnt - base_rd != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL double_start: got %0d done pulses %0d reads %0d left, required 1 8 0",
               done_cnt - base_done, rd_cnt - base_rd, sb.size());
    end
  endtask

  task automatic test_reset_mid_job();
    int base_hs;
    int base_done;
    bit seen;
    base_hs        = hs_cnt;
    base_done      = done_cnt;
    sif.dout_ready = 1'b1;
    push_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (hs_cnt - base_hs >= 4) break;
      tick();
    end
    vectors++;
    if (hs_cnt - base_hs != 4) begin
      miscompares++;
      $display("FAIL abort_point: got %0d transfers, required 4", hs_cnt - base_hs);
    end
    reset = 1'b0;
    sb.delete();
    tick();
    tick();
    vectors++;
    if ({ram_re, ram_addr, sif.dout, sif.dout_valid, sif.dout_last, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got re=%0b addr=%0d dout=%0d v=%0b l=%0b busy=%0b done=%0b, required all 0",
               ram_re, ram_addr, sif.dout, sif.dout_valid, sif.dout_last, busy, done);
    end
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (done_cnt != base_done) begin
      miscompares++;
      $display("FAIL abort_done: got %0d done pulses, required 0", done_cnt - base_done);
    end
    push_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, seen);
    vectors++;
    if (!seen || sb.size() != 0 || done_cnt - base_done != 1) begin
      miscompares++;
      $display("FAIL restart: got done=%0b %0d left %0d pulses, required done=1 0 left 1 pulse",
               seen, sb.size(), done_cnt - base_done);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_toggle_ready();
    test_stall();
    test_double_start();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
